// File: rtl/mult_div_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package mult_div_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  localparam int unsigned ITER_COUNT    = 32;
  localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

  function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mult_div_iter.sv
// One combinational iteration: shift-add multiply step or restore-subtract divide step.
module mult_div_iter #(
  parameter int unsigned W = 32
) (
  input  logic           is_div,
  input  logic [2*W-1:0] acc_i,
  input  logic [W-1:0]   operand_i,
  output logic [2*W-1:0] acc_o
);

  logic [W:0] sum;
  logic [W:0] trial;
  logic [W:0] diff;

  always_comb begin
    sum   = {1'b0, acc_i[2*W-1:W]} + (acc_i[0] ? {1'b0, operand_i} : '0);
    trial = {acc_i[2*W-1:W], acc_i[W-1]};
    diff  = trial - {1'b0, operand_i};
    if (is_div) begin
      // Borrow out of the trial subtraction means the remainder is restored.
      acc_o = diff[W] ? {trial[W-1:0], acc_i[W-2:0], 1'b0}
                      : {diff[W-1:0],  acc_i[W-2:0], 1'b1};
    end else begin
      acc_o = {sum, acc_i[W-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, with start/busy/done handshake.
// Define MULTDIV_FAST_MUL_EN for a single-cycle multiplier (divides stay iterative).
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             hi_we,
  input  logic             lo_we,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned DW = 2 * WIDTH;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [DW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic             neg_q, neg_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic [DW-1:0]    acc_step;
  logic [DW-1:0]    product;
  logic [DW-1:0]    prod_fix;
  op_e              op_in;
  logic             in_signed;
  logic             in_div;
  logic             is_div_q;

  assign is_div_q = (op_q == OP_DIV) || (op_q == OP_DIVU);

  mult_div_iter #(.W(WIDTH)) u_iter (
    .is_div    (is_div_q),
    .acc_i     (acc_q),
    .operand_i (mag_q),
    .acc_o     (acc_step)
  );

`ifdef MULTDIV_FAST_MUL_EN
  // Fast path reuses the latched magnitudes: |rs| in mag_q, |rt| in the low accumulator half.
  assign product = {{WIDTH{1'b0}}, mag_q} * {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]};
`else
  assign product = acc_q;
`endif

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mag_d     = mag_q;
    dvd_d     = dvd_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dbz_d     = dbz_q;
    op_in     = op_e'(op);
    in_signed = (op_in == OP_MULT) || (op_in == OP_DIV);
    in_div    = (op_in == OP_DIV) || (op_in == OP_DIVU);
    prod_fix  = neg_q ? (~product + {{(DW-1){1'b0}}, 1'b1}) : product;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d      = op_in;
          cnt_d     = '0;
          dbz_d     = 1'b0;
          busy_d    = 1'b1;
          dvd_d     = rs_data;
          neg_d     = in_signed && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
          neg_rem_d = in_signed && rs_data[WIDTH-1];
          // Divide: acc = {rem, dividend}, operand = divisor; multiply: acc = {0, B}, operand = A.
          mag_d     = in_div ? abs32(rt_data, in_signed) : abs32(rs_data, in_signed);
          acc_d     = {{WIDTH{1'b0}}, (in_div ? abs32(rs_data, in_signed)
                                              : abs32(rt_data, in_signed))};
`ifdef MULTDIV_FAST_MUL_EN
          state_d   = in_div ? ST_CALC : ST_FIX;
`else
          state_d   = ST_CALC;
`endif
        end else begin
          if (hi_we) hi_d = rs_data;
          if (lo_we) lo_d = rs_data;
        end
      end
      ST_CALC: begin
        acc_d = acc_step;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(ITER_COUNT - 1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (is_div_q) begin
          if (mag_q == '0) begin
            lo_d  = DIV_ZERO_QUOT;
            hi_d  = dvd_q;
            dbz_d = 1'b1;
          end else begin
            lo_d = neg_q     ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
            hi_d = neg_rem_q ? (~acc_q[DW-1:WIDTH] + 1'b1) : acc_q[DW-1:WIDTH];
          end
        end else begin
          hi_d = prod_fix[DW-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_MULT;
      cnt_q     <= '0;
      acc_q     <= '0;
      mag_q     <= '0;
      dvd_q     <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mag_q     <= mag_d;
      dvd_q     <= dvd_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        hi_we;
  logic        lo_we;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

`ifdef MULTDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural result computed with plain 64-bit arithmetic.
  task automatic ref_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] rh, output logic [31:0] rl, output logic dz);
    logic signed [63:0] sa, sb, sp, sq, sr;
    logic [63:0] ua, ub, up;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    dz = 1'b0;
    rh = '0;
    rl = '0;
    case (o)
      2'd0: begin sp = sa * sb; rh = sp[63:32]; rl = sp[31:0]; end
      2'd1: begin up = ua * ub; rh = up[63:32]; rl = up[31:0]; end
      default: begin
        if (b == 32'd0) begin
          dz = 1'b1; rl = 32'hFFFF_FFFF; rh = a;
        end else if (o == 2'd2) begin
          sq = sa / sb; sr = sa % sb; rl = sq[31:0]; rh = sr[31:0];
        end else begin
          up = ua / ub; rl = up[31:0]; up = ua % ub; rh = up[31:0];
        end
      end
    endcase
  endtask

  // Called at a negedge; asserts start now and returns at the negedge where done is seen.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input string tag, input bit disturb);
    logic [31:0] eh, el;
    logic        ez;
    int n, bc, lat_exp;
    ref_op(o, a, b, eh, el, ez);
    lat_exp = (FAST && !o[1]) ? 2 : 34;
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    @(negedge clk);
    start = 1'b0; rs_data = $urandom; rt_data = $urandom;
    n = 1; bc = 0;
    chk({tag, "_dbz_clr"}, {31'd0, div_by_zero}, 32'd0);
    while (!done && n < 100) begin
      if (busy) bc++;
      if (disturb && n == 5) begin
        start = 1'b1; op = 2'd1; rs_data = 32'hDEAD_BEEF; rt_data = 32'd3;
        hi_we = 1'b1; lo_we = 1'b1;
      end else begin
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    hi_we = 1'b0; lo_we = 1'b0;
    chk({tag, "_latency"}, n, lat_exp);
    chk({tag, "_busy_cycles"}, bc, lat_exp - 1);
    chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    chk({tag, "_hi"}, hi, eh);
    chk({tag, "_lo"}, lo, el);
    chk({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, ez});
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    int dones;
    rst_n = 1'b0; start = 1'b0; op = '0; rs_data = '0; rt_data = '0;
    hi_we = 1'b0; lo_we = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", 1'b0);
    chk("multu_max_hi_const", hi, 32'hFFFF_FFFE);
    chk("multu_max_lo_const", lo, 32'h0000_0001);
    @(negedge clk);
    chk("done_single_pulse", {31'd0, done}, 32'd0);

    do_op(2'd0, 32'hFFFF_FFFD, 32'd7, "mult_neg", 1'b0);
    chk("mult_neg_hi_const", hi, 32'hFFFF_FFFF);
    chk("mult_neg_lo_const", lo, 32'hFFFF_FFEB);
    @(negedge clk);
    do_op(2'd2, 32'hFFFF_FFF9, 32'd2, "div_neg", 1'b0);
    chk("div_neg_lo_const", lo, 32'hFFFF_FFFD);
    @(negedge clk);
    do_op(2'd3, 32'd100, 32'd7, "divu", 1'b0);
    @(negedge clk);
    do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 1'b0);
    chk("div_ovf_lo_const", lo, 32'h8000_0000);
    @(negedge clk);
    do_op(2'd3, 32'd5, 32'd0, "divu_zero", 1'b0);
    @(negedge clk);
    chk("dbz_held", {31'd0, div_by_zero}, 32'd1);
    do_op(2'd3, 32'd100, 32'd7, "disturbed", 1'b1);
    do_op(2'd0, 32'h0001_2345, 32'hFFFF_0003, "b2b_first", 1'b0);
    do_op(2'd2, 32'hFFFF_FC18, 32'd13, "b2b_second", 1'b0);
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      else if ($urandom_range(0, 1) == 1) rb = $urandom;
      else rb = 32'($urandom_range(1, 50));
      do_op(ro, ra, rb, $sformatf("rand%0d", i), 1'b0);
      @(negedge clk);
    end

    hi_we = 1'b1; lo_we = 1'b1; rs_data = 32'hCAFE_0001;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    chk("mt_both_hi", hi, 32'hCAFE_0001);
    chk("mt_both_lo", lo, 32'hCAFE_0001);
    chk("mt_both_done", {31'd0, done}, 32'd0);
    chk("mt_both_busy", {31'd0, busy}, 32'd0);

    start = 1'b1; op = 2'd2; rs_data = 32'd1000; rt_data = 32'hFFFF_FFFD;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    lo_we = 1'b1; rs_data = 32'h0000_1234;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mtlo_lo", lo, 32'h0000_1234);
    chk("mtlo_hi", hi, 32'd0);
    chk("mtlo_done", {31'd0, done}, 32'd0);
    chk("mtlo_busy", {31'd0, busy}, 32'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("lost_op_no_done", dones, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit sitting downstream of the register bank: it consumes the two register read operands (rs, rt) of MULT/MULTU/DIV/DIVU and produces the architectural HI/LO pair read back by MFHI/MFLO. A start/busy/done handshake lets the control unit stall the pipeline while an operation runs. MTHI/MTLO write HI/LO directly from the rs operand.

## Interface
Parameters:
- WIDTH, 32, operand and HI/LO width; only 32 is supported.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a new operation; sampled only when busy=0.
- op  input  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU; sampled with start.
- rs_data  input  32  operand A / dividend; also MTHI/MTLO write data.
- rt_data  input  32  operand B / divisor.
- hi_we  input  1  MTHI: HI <= rs_data.
- lo_we  input  1  MTLO: LO <= rs_data.
- busy  output  1  operation in flight; control unit stalls on it.
- done  output  1  one-cycle pulse, HI/LO just updated.
- div_by_zero  output  1  set with done when a DIV/DIVU had rt_data=0; held until next accepted start.
- hi  output  32  HI register.
- lo  output  32  LO register.

## Operation
- States: IDLE, CALC, FIX.
- IDLE: start=1 latches op, rs_data, rt_data; clears counter and div_by_zero; goes to CALC. start ignored while busy=1.
- CALC: one iteration per cycle, 32 cycles, counter 0..31.
  - MULT/MULTU: shift-add on magnitudes, 64-bit accumulator.
  - DIV/DIVU: restoring division on magnitudes, 32-bit quotient, 32-bit remainder.
  - Signed ops take absolute values at latch time; sign fix happens in FIX.
- FIX (one cycle): apply sign, write HI/LO, pulse done, return to IDLE.
  - MULT/MULTU: HI = product[63:32], LO = product[31:0].
  - DIV/DIVU: LO = quotient, HI = remainder. Quotient truncates toward zero; remainder takes the dividend's sign.
  - DIV of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero: LO=0xFFFFFFFF, HI=dividend unchanged, div_by_zero=1. Latency is the same as a normal divide.
- hi_we/lo_we act only in IDLE, with start=0. If asserted together with an accepted start, or while busy, the writes are discarded. hi_we and lo_we may both be asserted in the same cycle.
- Reset (at any time, including mid-operation): state=IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0; the operation in flight is lost.

## Timing
- start accepted at edge E0. busy=1 from after E0 through the cycle before done.
- HI/LO are written at edge E33. done=1 and busy=0 in the cycle following E33.
- Total latency is 34 edges from start to visible result.
- A new start in the same cycle that done is high is accepted.
- MTHI/MTLO take effect at the next edge, with no busy or done activity.
- hi/lo are registered outputs and stay stable throughout CALC.

## Configuration
- MULTDIV_FAST_MUL_EN defined: MULT/MULTU use a single-cycle 32x32 multiplier.
  - Flow is IDLE -> FIX; result written at E1; done high in the cycle after E1.
  - busy is high for one cycle.
  - Divides are unchanged.
- Undefined: every op uses the iterative 34-edge path.

## Structure
- Package mult_div_pkg holds:
  - op encoding enum (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU);
  - state enum (ST_IDLE, ST_CALC, ST_FIX);
  - ITER_COUNT=32;
  - DIV_ZERO_QUOT=32'hFFFF_FFFF.
- One sub-module, mult_div_iter: pure one-step datapath (shift-add step / restore-subtract step), combinational. The FSM, counter and HI/LO registers stay in mult_div_unit.

## Test plan
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> after 34 edges HI=0xFFFFFFFE, LO=0x00000001, single done pulse, busy high exactly 33 cycles.
- MULT -3 x 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; with MULTDIV_FAST_MUL_EN, same result with done one cycle after start.
- DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100 / 7 -> LO=14, HI=2; DIV 0x80000000 / -1 -> LO=0x80000000, HI=0.
- DIVU 5 / 0 -> LO=0xFFFFFFFF, HI=5, div_by_zero=1 with done; next accepted start clears div_by_zero.
- start pulsed while busy and hi_we asserted mid-operation -> both ignored, original result delivered; start in the done cycle -> accepted back-to-back.
- rst_n dropped at iteration 10 of a DIV -> hi=lo=0, busy=0 immediately; after release, MTLO 0x1234 -> lo=0x1234 next edge, no done pulse.
